// File: rtl/lc3_control_fsm.sv
// LC-3 microsequencer: walks fetch/decode/execute and drives every datapath control strobe.
// Control outputs are a Moore decode of the state register, held low while reset is asserted.
module lc3_control_fsm #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [15:0] i_IR,
    input  logic        i_N,
    input  logic        i_Z,
    input  logic        i_P,
    input  logic        i_Mem_R,
    output logic        o_LD_MAR,
    output logic        o_LD_MDR,
    output logic        o_LD_IR,
    output logic        o_LD_PC,
    output logic        o_LD_REG,
    output logic        o_LD_CC,
    output logic        o_GATE_PC,
    output logic        o_GATE_MDR,
    output logic        o_GATE_ALU,
    output logic        o_GATE_MARMUX,
    output logic [1:0]  o_PCMUX,
    output logic        o_ADDR1MUX,
    output logic [1:0]  o_ADDR2MUX,
    output logic        o_SR1MUX,
    output logic [1:0]  o_ALUK,
    output logic        o_MIO_EN,
    output logic        o_R_W,
    output logic        o_Illegal,
    output logic        o_Mem_Err,
    output logic [4:0]  o_State
);

    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    typedef enum logic [4:0] {
        FETCH0  = 5'd0,
        FETCH1  = 5'd1,
        FETCH2  = 5'd2,
        DECODE  = 5'd3,
        ADD     = 5'd4,
        AND     = 5'd5,
        NOT     = 5'd6,
        BR0     = 5'd7,
        BR1     = 5'd8,
        JMP     = 5'd9,
        LD0     = 5'd10,
        LD1     = 5'd11,
        LD2     = 5'd12,
        ST0     = 5'd13,
        ST1     = 5'd14,
        ST2     = 5'd15,
        ILLEGAL = 5'd30,
        ERROR   = 5'd31
    } state_t;

    state_t          state;
    state_t          wait_next;
    logic [CW-1:0]   wait_cnt;
    logic            illegal_q;
    logic            mem_err_q;
    logic            ben;
    logic            ir_unused;

    assign ben       = (i_IR[11] & i_N) | (i_IR[10] & i_Z) | (i_IR[9] & i_P);
    assign ir_unused = ^i_IR[8:0];

    always_comb begin
        wait_next = FETCH2;
        case (state)
            LD1:     wait_next = LD2;
            ST2:     wait_next = FETCH0;
            default: wait_next = FETCH2;
        endcase
    end

    // The wait counter only survives a cycle spent stalling in a wait state,
    // so it is automatically zero on every entry to FETCH1, LD1 or ST2.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= FETCH0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH0: state <= FETCH1;
                FETCH1, LD1, ST2: begin
                    if (i_Mem_R) begin
                        state <= wait_next;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ERROR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FETCH2: state <= DECODE;
                DECODE: begin
                    case (i_IR[15:12])
                        4'b0001: state <= ADD;
                        4'b0101: state <= AND;
                        4'b1001: state <= NOT;
                        4'b0000: state <= BR0;
                        4'b1100: state <= JMP;
                        4'b0010: state <= LD0;
                        4'b0011: state <= ST0;
                        default: begin
                            state     <= ILLEGAL;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                ADD, AND, NOT: state <= FETCH0;
                BR0:     state <= ben ? BR1 : FETCH0;
                BR1:     state <= FETCH0;
                JMP:     state <= FETCH0;
                LD0:     state <= LD1;
                LD2:     state <= FETCH0;
                ST0:     state <= ST1;
                ST1:     state <= ST2;
                ILLEGAL: state <= ILLEGAL;
                ERROR:   state <= ERROR;
                default: state <= FETCH0;
            endcase
        end
    end

    // Reset masks the decode so nothing is strobed while FETCH0 is being forced.
    always_comb begin
        o_LD_MAR      = 1'b0;
        o_LD_MDR      = 1'b0;
        o_LD_IR       = 1'b0;
        o_LD_PC       = 1'b0;
        o_LD_REG      = 1'b0;
        o_LD_CC       = 1'b0;
        o_GATE_PC     = 1'b0;
        o_GATE_MDR    = 1'b0;
        o_GATE_ALU    = 1'b0;
        o_GATE_MARMUX = 1'b0;
        o_PCMUX       = 2'b00;
        o_ADDR1MUX    = 1'b0;
        o_ADDR2MUX    = 2'b00;
        o_SR1MUX      = 1'b0;
        o_ALUK        = 2'b00;
        o_MIO_EN      = 1'b0;
        o_R_W         = 1'b0;
        if (!i_Reset) begin
            case (state)
                FETCH0: begin
                    o_GATE_PC = 1'b1;
                    o_LD_MAR  = 1'b1;
                    o_LD_PC   = 1'b1;
                end
                FETCH1, LD1: begin
                    o_MIO_EN = 1'b1;
                    o_LD_MDR = 1'b1;
                end
                FETCH2: begin
                    o_GATE_MDR = 1'b1;
                    o_LD_IR    = 1'b1;
                end
                ADD, AND, NOT: begin
                    o_SR1MUX   = 1'b1;
                    o_ALUK     = (state == ADD) ? 2'b00 : (state == AND) ? 2'b01 : 2'b10;
                    o_GATE_ALU = 1'b1;
                    o_LD_REG   = 1'b1;
                    o_LD_CC    = 1'b1;
                end
                BR1: begin
                    o_ADDR2MUX = 2'b10;
                    o_PCMUX    = 2'b10;
                    o_LD_PC    = 1'b1;
                end
                JMP: begin
                    o_SR1MUX   = 1'b1;
                    o_ADDR1MUX = 1'b1;
                    o_PCMUX    = 2'b10;
                    o_LD_PC    = 1'b1;
                end
                LD0, ST0: begin
                    o_ADDR2MUX    = 2'b10;
                    o_GATE_MARMUX = 1'b1;
                    o_LD_MAR      = 1'b1;
                end
                LD2: begin
                    o_GATE_MDR = 1'b1;
                    o_LD_REG   = 1'b1;
                    o_LD_CC    = 1'b1;
                end
                ST1: begin
                    o_ALUK     = 2'b11;
                    o_GATE_ALU = 1'b1;
                    o_LD_MDR   = 1'b1;
                end
                ST2: begin
                    o_MIO_EN = 1'b1;
                    o_R_W    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_Illegal = illegal_q;
    assign o_Mem_Err = mem_err_q;
    assign o_State   = state;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: directed instruction table, randomized instruction stream
// against an instruction-level model, and hand sequences for timeout and mid-access reset.
module tb_lc3_control_fsm;

    logic        i_Clk;
    logic        i_Reset;
    logic [15:0] i_IR;
    logic        i_N, i_Z, i_P;
    logic        i_Mem_R;
    logic        o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_PC, o_LD_REG, o_LD_CC;
    logic        o_GATE_PC, o_GATE_MDR, o_GATE_ALU, o_GATE_MARMUX;
    logic [1:0]  o_PCMUX;
    logic        o_ADDR1MUX;
    logic [1:0]  o_ADDR2MUX;
    logic        o_SR1MUX;
    logic [1:0]  o_ALUK;
    logic        o_MIO_EN, o_R_W, o_Illegal, o_Mem_Err;
    logic [4:0]  o_State;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic       sr1mux;
        logic [1:0] aluk;
        logic       mio_en, r_w, illegal, mem_err;
    } ctl_t;

    typedef struct {
        int st;
        bit memR;
    } cyc_t;

    typedef struct {
        logic [15:0] ir;
        logic        n, z, p;
        int          fetchStall;
        int          memStall;
        int          expCycles;
    } vec_t;

    ctl_t dutCtl;
    cyc_t seq[$];
    vec_t vecs[$];
    int   passCount = 0;
    int   checkCount = 0;

    assign dutCtl = {o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_PC, o_LD_REG, o_LD_CC,
                     o_GATE_PC, o_GATE_MDR, o_GATE_ALU, o_GATE_MARMUX,
                     o_PCMUX, o_ADDR1MUX, o_ADDR2MUX, o_SR1MUX, o_ALUK,
                     o_MIO_EN, o_R_W, o_Illegal, o_Mem_Err};

    lc3_control_fsm #(.MEM_WAIT_MAX(15)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_IR(i_IR),
        .i_N(i_N), .i_Z(i_Z), .i_P(i_P), .i_Mem_R(i_Mem_R),
        .o_LD_MAR(o_LD_MAR), .o_LD_MDR(o_LD_MDR), .o_LD_IR(o_LD_IR),
        .o_LD_PC(o_LD_PC), .o_LD_REG(o_LD_REG), .o_LD_CC(o_LD_CC),
        .o_GATE_PC(o_GATE_PC), .o_GATE_MDR(o_GATE_MDR), .o_GATE_ALU(o_GATE_ALU),
        .o_GATE_MARMUX(o_GATE_MARMUX), .o_PCMUX(o_PCMUX), .o_ADDR1MUX(o_ADDR1MUX),
        .o_ADDR2MUX(o_ADDR2MUX), .o_SR1MUX(o_SR1MUX), .o_ALUK(o_ALUK),
        .o_MIO_EN(o_MIO_EN), .o_R_W(o_R_W), .o_Illegal(o_Illegal),
        .o_Mem_Err(o_Mem_Err), .o_State(o_State)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input logic [15:0] ir, input logic n, input logic z,
                                 input logic p, input logic memR);
        i_IR    = ir;
        i_N     = n;
        i_Z     = z;
        i_P     = p;
        i_Mem_R = memR;
    endtask

    // Control word each state is documented to produce.
    function automatic ctl_t expCtl(input int st);
        ctl_t c = '0;
        case (st)
            0:  begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
            1:  begin c.mio_en = 1; c.ld_mdr = 1; end
            2:  begin c.gate_mdr = 1; c.ld_ir = 1; end
            4:  begin c.sr1mux = 1; c.aluk = 2'b00; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
            5:  begin c.sr1mux = 1; c.aluk = 2'b01; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
            6:  begin c.sr1mux = 1; c.aluk = 2'b10; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
            8:  begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; end
            9:  begin c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1; end
            10, 13: begin c.addr2mux = 2'b10; c.gate_marmux = 1; c.ld_mar = 1; end
            11: begin c.mio_en = 1; c.ld_mdr = 1; end
            12: begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
            14: begin c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; end
            15: begin c.mio_en = 1; c.r_w = 1; end
            30: c.illegal = 1;
            31: c.mem_err = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic void addCyc(input int st);
        seq.push_back('{st, 1'($urandom)});
    endfunction

    function automatic void addAccess(input int st, input int stall);
        for (int j = 0; j < stall; j++) seq.push_back('{st, 1'b0});
        seq.push_back('{st, 1'b1});
    endfunction

    // Instruction-level model: expected per-cycle state trace plus the memory-ready schedule.
    function automatic bit buildSeq(input vec_t v);
        logic [3:0] op;
        bit         taken;
        op = v.ir[15:12];
        seq.delete();
        addCyc(0);
        addAccess(1, v.fetchStall);
        addCyc(2);
        addCyc(3);
        case (op)
            4'h1: addCyc(4);
            4'h5: addCyc(5);
            4'h9: addCyc(6);
            4'h0: begin
                taken = (v.ir[11] && v.n) || (v.ir[10] && v.z) || (v.ir[9] && v.p);
                addCyc(7);
                if (taken) addCyc(8);
            end
            4'hC: addCyc(9);
            4'h2: begin addCyc(10); addAccess(11, v.memStall); addCyc(12); end
            4'h3: begin addCyc(13); addCyc(14); addAccess(15, v.memStall); end
            default: begin
                for (int j = 0; j < 4; j++) addCyc(30);
                return 1'b1;
            end
        endcase
        return 1'b0;
    endfunction

    task automatic doReset();
        #2;
        i_Reset = 1'b1;
        applyStimulus(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        #1;
        checkOutput("reset state", 32'(o_State), 32'd0);
        checkOutput("reset ctl", 32'(dutCtl), 32'd0);
        @(negedge i_Clk);
        i_Reset = 1'b0;
        #1;
    endtask

    // Starts with the DUT in FETCH0; ends at the negedge where it is back in FETCH0.
    task automatic runInstr(input vec_t v, input int expLat, input string tag);
        bit   terminal;
        int   i;
        int   lat;
        bit   done;
        logic memR;
        terminal = buildSeq(v);
        lat  = (expLat < 0) ? seq.size() : expLat;
        i    = 0;
        done = 1'b0;
        while (!done) begin
            memR = 1'b1;
            if (i < seq.size()) begin
                checkOutput($sformatf("%s c%0d state", tag, i), 32'(o_State), 32'(seq[i].st));
                checkOutput($sformatf("%s c%0d ctl", tag, i), 32'(dutCtl), 32'(expCtl(seq[i].st)));
                checkOutput($sformatf("%s c%0d gates", tag, i),
                            32'($countones({o_GATE_PC, o_GATE_MDR, o_GATE_ALU, o_GATE_MARMUX}) <= 1), 32'd1);
                memR = seq[i].memR;
            end
            applyStimulus(v.ir, v.n, v.z, v.p, memR);
            @(negedge i_Clk);
            i++;
            if (terminal && i == seq.size()) done = 1'b1;
            if (!terminal && o_State == 5'd0) done = 1'b1;
            if (i >= 80) done = 1'b1;
        end
        if (!terminal) checkOutput($sformatf("%s latency", tag), 32'(i), 32'(lat));
        else doReset();
    endtask

    initial begin
        vec_t v;
        logic [3:0] ops[12];
        i_Reset = 1'b0;
        applyStimulus(16'h0000, 0, 0, 0, 1);

        vecs.push_back('{16'h1042, 1'b0, 1'b0, 1'b0, 0, 0, 5});
        vecs.push_back('{16'h5042, 1'b0, 1'b1, 1'b0, 0, 0, 5});
        vecs.push_back('{16'h927F, 1'b1, 1'b0, 1'b0, 0, 0, 5});
        vecs.push_back('{16'h0A05, 1'b1, 1'b0, 1'b0, 0, 0, 6});
        vecs.push_back('{16'h0A05, 1'b0, 1'b1, 1'b0, 0, 0, 5});
        vecs.push_back('{16'h0205, 1'b0, 1'b0, 1'b1, 0, 0, 6});
        vecs.push_back('{16'h01FF, 1'b1, 1'b1, 1'b1, 0, 0, 5});
        vecs.push_back('{16'hC1C0, 1'b0, 1'b0, 1'b0, 0, 0, 5});
        vecs.push_back('{16'h2205, 1'b0, 1'b0, 1'b0, 0, 3, 10});
        vecs.push_back('{16'h2205, 1'b0, 1'b0, 1'b0, 0, 0, 7});
        vecs.push_back('{16'h3405, 1'b0, 1'b0, 1'b0, 0, 0, 7});
        vecs.push_back('{16'h3405, 1'b0, 1'b0, 1'b0, 14, 14, 35});
        vecs.push_back('{16'h1042, 1'b0, 1'b0, 1'b0, 2, 0, 7});
        vecs.push_back('{16'hD000, 1'b0, 1'b0, 1'b0, 0, 0, 0});
        vecs.push_back('{16'hF025, 1'b0, 1'b0, 1'b0, 1, 0, 0});

        #1;
        doReset();
        for (int k = 0; k < vecs.size(); k++)
            runInstr(vecs[k], vecs[k].expCycles, $sformatf("vec%0d ir=%h", k, vecs[k].ir));

        ops = '{4'h1, 4'h5, 4'h9, 4'h0, 4'h0, 4'hC, 4'h2, 4'h3, 4'h2, 4'h4, 4'h8, 4'hE};
        for (int k = 0; k < 40; k++) begin
            v.ir         = {ops[$urandom_range(0, 11)], 12'($urandom)};
            v.n          = 1'($urandom);
            v.z          = 1'($urandom);
            v.p          = 1'($urandom);
            v.fetchStall = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            v.memStall   = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
            v.expCycles  = -1;
            runInstr(v, -1, $sformatf("rnd%0d ir=%h", k, v.ir));
        end

        // Fetch timeout: 15 stalled cycles in FETCH1, then ERROR until reset.
        doReset();
        applyStimulus(16'h1042, 0, 0, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge i_Clk);
            if (c == 15) checkOutput("timeout last wait", 32'(o_State), 32'd1);
            if (c == 16) checkOutput("timeout error state", 32'(o_State), 32'd31);
        end
        i_Mem_R = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_Clk);
            checkOutput("error held state", 32'(o_State), 32'd31);
            checkOutput("error held ctl", 32'(dutCtl), 32'(expCtl(31)));
        end

        // Reset in the middle of a stalled LD1 access.
        doReset();
        applyStimulus(16'h2205, 0, 0, 0, 1);
        for (int c = 0; c < 5; c++) @(negedge i_Clk);
        i_Mem_R = 1'b0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        checkOutput("mid LD1 state", 32'(o_State), 32'd11);
        #2;
        i_Reset = 1'b1;
        #1;
        checkOutput("mid reset state", 32'(o_State), 32'd0);
        checkOutput("mid reset ctl", 32'(dutCtl), 32'd0);
        @(negedge i_Clk);
        i_Reset = 1'b0;
        #1;
        checkOutput("post reset state", 32'(o_State), 32'd0);
        checkOutput("post reset ctl", 32'(dutCtl), 32'(expCtl(0)));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
